// File: rtl/isa_pkg.sv
// -----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the instruction memory block.
//   INSTR_W      : instruction word width in bits
//   PC_W         : program-counter width
//   IMEM_DEPTH   : number of instruction words (2**PC_W)
//   imem_state_t : loader / fetch FSM states
// -----------------------------------------------------------------------------
package isa_pkg;

   localparam int INSTR_W    = 9;
   localparam int PC_W       = 8;
   localparam int IMEM_DEPTH = 2 ** PC_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Simple dual-port instruction storage: one write port, one read port with a
// registered output (one-cycle read latency). Contents are never cleared.
// Ports:
//   clock   : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every rising edge
//   rd_data : registered read data
// -----------------------------------------------------------------------------
module imem_ram #(
   parameter int DATA_W = isa_pkg::INSTR_W,
   parameter int ADDR_W = isa_pkg::PC_W
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];
   logic [DATA_W-1:0] r_rd_data;

   // Read-during-write to the same address returns the old word; the fetch
   // side never depends on that case because fetch is only valid in RUN.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
      r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem
// Instruction memory with a streaming program loader. A load_start pulse
// restarts loading at address 0; words are accepted while wr_valid and
// wr_ready are both high. The final word (wr_last, or the last address) moves
// the block into RUN, where pc is fetched with one cycle of latency.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   load_start   : begin a new program load at address 0
//   wr_valid     : loader presents wr_data
//   wr_data      : instruction word being loaded
//   wr_last      : wr_data is the final word of the program
//   wr_ready     : block accepts wr_data this cycle (LOAD only)
//   pc           : fetch address
//   instruction  : registered fetch data (0 outside RUN or beyond program)
//   inst_valid   : instruction is valid for the pc of the previous cycle
//   loaded       : a complete program is resident
//   load_count   : words written by the current/last load (0..2**PC_W)
// -----------------------------------------------------------------------------
module instr_mem #(
   parameter int INSTR_W = isa_pkg::INSTR_W,
   parameter int PC_W    = isa_pkg::PC_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load_start,
   input  logic               wr_valid,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               wr_last,
   output logic               wr_ready,
   input  logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instruction,
   output logic               inst_valid,
   output logic               loaded,
   output logic [PC_W:0]      load_count
);

   import isa_pkg::*;

   imem_state_t        r_state;
   logic [PC_W-1:0]    r_wr_addr;
   logic [PC_W:0]      r_load_count;
   logic               r_loaded;
   logic               r_wr_ready;
   logic               r_inst_valid;
   logic               r_rd_gate;
   logic               w_wr_en;
   logic               w_addr_max;
   logic [INSTR_W-1:0] w_rd_data;

   // load_start and reset both override a coincident write.
   assign w_wr_en    = (r_state == LOAD) && wr_valid && !load_start && !reset;
   assign w_addr_max = &r_wr_addr;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_wr_addr    <= '0;
         r_load_count <= '0;
         r_loaded     <= 1'b0;
         r_wr_ready   <= 1'b0;
         r_inst_valid <= 1'b0;
         r_rd_gate    <= 1'b0;
      end else begin
         r_inst_valid <= 1'b0;
         r_rd_gate    <= 1'b0;
         if (load_start) begin
            r_state      <= LOAD;
            r_wr_addr    <= '0;
            r_load_count <= '0;
            r_loaded     <= 1'b0;
            r_wr_ready   <= 1'b1;
         end else begin
            case (r_state)
               IDLE: begin
                  r_wr_ready <= 1'b0;
               end
               LOAD: begin
                  if (wr_valid) begin
                     r_load_count <= r_load_count + 1'b1;
                     // The address saturates; the top word always ends the load.
                     if (!w_addr_max) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                     end
                     if (wr_last || w_addr_max) begin
                        r_state    <= RUN;
                        r_loaded   <= 1'b1;
                        r_wr_ready <= 1'b0;
                     end
                  end
               end
               RUN: begin
                  // Valid from the second RUN cycle on; the first cycle's
                  // read data was sampled while still in LOAD.
                  r_inst_valid <= 1'b1;
                  r_rd_gate    <= ({1'b0, pc} < r_load_count);
               end
               default: begin
                  r_state    <= IDLE;
                  r_wr_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   imem_ram #(
      .DATA_W (INSTR_W),
      .ADDR_W (PC_W)
   ) u_ram (
      .clock   (clock),
      .wr_en   (w_wr_en),
      .wr_addr (r_wr_addr),
      .wr_data (wr_data),
      .rd_addr (pc),
      .rd_data (w_rd_data)
   );

   // Out-of-program addresses and non-RUN states read as NOP (all zeros).
   assign instruction = r_rd_gate ? w_rd_data : '0;
   assign inst_valid  = r_inst_valid;
   assign wr_ready    = r_wr_ready;
   assign loaded      = r_loaded;
   assign load_count  = r_load_count;

endmodule
